wb_port_arbiter: RTL

Shares the single register-file write port between the in-order pipeline writeback (execute-stage result) and a secondary multi-cycle result source (load/multiply/divide unit). It replaces the plain writeback stage register: a registered write is presented to the register file one cycle after grant. It buffers up to two secondary results and enforces a starvation bound by stalling the pipeline for one cycle. It also discards buffered secondary results superseded by a newer pipeline write to the same destination.

---
 rtl/wb_port_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. a 2-deep buffer of
// secondary (load/mul/div) results, with a starvation-forced grant and kill of stale entries.
module wb_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_e,
    input  logic [15:0] wdata_e,
    input  logic [3:0]  dest_e,
    output logic        stall_e,
    input  logic        req_m,
    input  logic [15:0] wdata_m,
    input  logic [3:0]  dest_m,
    output logic        ack_m,
    output logic [15:0] wdata_w,
    output logic [3:0]  dest_w,
    output logic        we_w,
    output logic        src_w,
    output logic [1:0]  pend_m
);
    typedef enum logic {NORM, FORCE} state_t;

    state_t            r_state;
    logic [1:0][15:0]  r_data;
    logic [1:0][3:0]   r_dest;
    logic [1:0]        r_kill;
    logic [1:0]        r_cnt;
    logic [2:0]        r_starve;

    logic [1:0][15:0]  w_data_n;
    logic [1:0][3:0]   w_dest_n;
    logic [1:0]        w_kill_n;
    logic [1:0]        w_cnt_n;
    logic              w_head_v, w_head_live;
    logic              w_grant_p, w_grant_h;
    logic              w_pop, w_push, w_wait, w_force;
    logic [2:0]        w_starve_inc;

    assign ack_m   = (r_cnt != 2'd2) && !rst;
    assign pend_m  = r_cnt;
    assign stall_e = (r_state == FORCE);

    assign w_head_v     = (r_cnt != 2'd0);
    assign w_head_live  = w_head_v && !r_kill[0];
    assign w_grant_p    = (r_state == NORM) && we_e;
    assign w_grant_h    = w_head_live && ((r_state == FORCE) || !we_e);
    // A killed head drains without touching the port, alongside any grant.
    assign w_pop        = w_head_v && (r_kill[0] || w_grant_h);
    assign w_push       = req_m && ack_m;
    assign w_wait       = w_head_live && !w_grant_h;
    assign w_starve_inc = r_starve + 3'd1;
    assign w_force      = (r_state == NORM) && w_wait && (w_starve_inc == 3'(STARVE_MAX));

    always_comb begin
        w_data_n = r_data;
        w_dest_n = r_dest;
        w_kill_n = r_kill;
        w_cnt_n  = r_cnt;
        if (w_pop) begin
            w_data_n[0] = r_data[1];
            w_dest_n[0] = r_dest[1];
            w_kill_n[0] = r_kill[1];
            w_cnt_n     = r_cnt - 2'd1;
        end
        if (w_push) begin
            w_data_n[w_cnt_n[0]] = wdata_m;
            w_dest_n[w_cnt_n[0]] = dest_m;
            w_kill_n[w_cnt_n[0]] = 1'b0;
            w_cnt_n              = w_cnt_n + 2'd1;
        end
        // Buffered results are older than the granted pipeline write, so they are stale.
        if (w_grant_p) begin
            for (int i = 0; i < 2; i++) begin
                if (w_dest_n[i] == dest_e)
                    w_kill_n[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= NORM;
            r_data   <= '0;
            r_dest   <= '0;
            r_kill   <= '0;
            r_cnt    <= 2'd0;
            r_starve <= 3'd0;
            wdata_w  <= 16'd0;
            dest_w   <= 4'd0;
            we_w     <= 1'b0;
            src_w    <= 1'b0;
        end else begin
            r_data   <= w_data_n;
            r_dest   <= w_dest_n;
            r_kill   <= w_kill_n;
            r_cnt    <= w_cnt_n;
            r_state  <= w_force ? FORCE : NORM;
            r_starve <= (w_wait && !w_force) ? w_starve_inc : 3'd0;
            if (w_grant_p) begin
                wdata_w <= wdata_e;
                dest_w  <= dest_e;
                we_w    <= 1'b1;
                src_w   <= 1'b0;
            end else if (w_grant_h) begin
                wdata_w <= r_data[0];
                dest_w  <= r_dest[0];
                we_w    <= 1'b1;
                src_w   <= 1'b1;
            end else begin
                we_w    <= 1'b0;
            end
        end
    end
endmodule
